// File: rtl/count_modn.sv
// Modulo-N watch digit: tick-enabled count, carry pulse, divided clock, load and set-mode adjust.
// One-cycle registered latency on all outputs; no backpressure, every tick/load/adjust is taken on its edge.
module count_modn #(
  parameter int MODULO = 6,
  parameter int WIDTH  = 4,
  parameter int IVAL   = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] ival_i,
  input  logic             adj_i,
  output logic [WIDTH-1:0] count_o,
  output logic             carry_o,
  output logic             clkdiv_o
);

  localparam int              HALF    = MODULO / 2;
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] HALF_M1 = WIDTH'(HALF - 1);
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(IVAL);
  // One extra bit so MODULO == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_V   = (WIDTH+1)'(MODULO);

  if (MODULO < 2 || MODULO > (2 ** WIDTH) || IVAL < 0 || IVAL >= MODULO) begin : g_param_err
    $error("count_modn: MODULO must be 2..2**WIDTH and IVAL must be below MODULO");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             clkdiv_q, clkdiv_d;
  logic             at_max;
  logic [WIDTH-1:0] count_inc;

  always_comb begin
    at_max    = (count_q == MAX_V);
    count_inc = at_max ? '0 : count_q + WIDTH'(1);
    count_d   = count_q;
    carry_d   = 1'b0;
    clkdiv_d  = clkdiv_q;
    if (load_i) begin
      count_d = ({1'b0, ival_i} < MOD_V) ? ival_i : '0;
    end else if (adj_i) begin
      count_d = count_inc;
    end else if (en_i) begin
      count_d = count_inc;
      carry_d = at_max;
      // Toggling at HALF-1 and MODULO-1 gives a HALF:(MODULO-HALF) duty cycle.
      if (at_max || (count_q == HALF_M1)) begin
        clkdiv_d = ~clkdiv_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= RST_V;
      carry_q  <= 1'b0;
      clkdiv_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      clkdiv_q <= clkdiv_d;
    end
  end

  assign count_o  = count_q;
  assign carry_o  = carry_q;
  assign clkdiv_o = clkdiv_q;

  a_count_range: assert property (@(posedge clk_i) disable iff (rst_i) count_q <= MAX_V);

endmodule

// File: tb/tb_count_modn.sv
// Bench for count_modn: several parameterisations plus a two-digit chain against a behavioural model.
module tb_count_modn;

  localparam int NI = 6;

  logic clk;
  logic rst;
  logic en_s   [NI];
  logic load_s [NI];
  logic adj_s  [NI];
  logic [3:0] ival_s [NI];

  logic [3:0] c0, c1, c4, c5;
  logic [2:0] c2;
  logic [0:0] c3;
  logic k0, k1, k2, k3, k4, k5;
  logic d0, d1, d2, d3, d4, d5;

  int mod_m [NI] = '{6, 10, 5, 2, 10, 6};
  int wid_m [NI] = '{4, 4, 3, 1, 4, 4};
  int rst_m [NI] = '{0, 7, 2, 1, 0, 0};
  int cnt_m [NI];
  bit car_m [NI];
  bit cd_m  [NI];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  count_modn #(.MODULO(6),  .WIDTH(4), .IVAL(0)) u6 (
    .clk_i(clk), .rst_i(rst), .en_i(en_s[0]), .load_i(load_s[0]), .ival_i(ival_s[0]),
    .adj_i(adj_s[0]), .count_o(c0), .carry_o(k0), .clkdiv_o(d0));
  count_modn #(.MODULO(10), .WIDTH(4), .IVAL(7)) u10 (
    .clk_i(clk), .rst_i(rst), .en_i(en_s[1]), .load_i(load_s[1]), .ival_i(ival_s[1]),
    .adj_i(adj_s[1]), .count_o(c1), .carry_o(k1), .clkdiv_o(d1));
  count_modn #(.MODULO(5),  .WIDTH(3), .IVAL(2)) u5 (
    .clk_i(clk), .rst_i(rst), .en_i(en_s[2]), .load_i(load_s[2]), .ival_i(ival_s[2][2:0]),
    .adj_i(adj_s[2]), .count_o(c2), .carry_o(k2), .clkdiv_o(d2));
  count_modn #(.MODULO(2),  .WIDTH(1), .IVAL(1)) u2 (
    .clk_i(clk), .rst_i(rst), .en_i(en_s[3]), .load_i(load_s[3]), .ival_i(ival_s[3][0:0]),
    .adj_i(adj_s[3]), .count_o(c3), .carry_o(k3), .clkdiv_o(d3));
  count_modn #(.MODULO(10), .WIDTH(4), .IVAL(0)) u_lo (
    .clk_i(clk), .rst_i(rst), .en_i(en_s[4]), .load_i(load_s[4]), .ival_i(ival_s[4]),
    .adj_i(adj_s[4]), .count_o(c4), .carry_o(k4), .clkdiv_o(d4));
  count_modn #(.MODULO(6),  .WIDTH(4), .IVAL(0)) u_hi (
    .clk_i(clk), .rst_i(rst), .en_i(k4), .load_i(load_s[5]), .ival_i(ival_s[5]),
    .adj_i(adj_s[5]), .count_o(c5), .carry_o(k5), .clkdiv_o(d5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dcnt(int i);
    case (i)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      3: return int'(c3);
      4: return int'(c4);
      default: return int'(c5);
    endcase
  endfunction

  function automatic int dcar(int i);
    case (i)
      0: return int'(k0);
      1: return int'(k1);
      2: return int'(k2);
      3: return int'(k3);
      4: return int'(k4);
      default: return int'(k5);
    endcase
  endfunction

  function automatic int dcd(int i);
    case (i)
      0: return int'(d0);
      1: return int'(d1);
      2: return int'(d2);
      3: return int'(d3);
      4: return int'(d4);
      default: return int'(d5);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: digit value advances (v+1) mod N; the divided clock flips whenever a
  // tick lands the digit on 0 or on N/2; the upper chained digit ticks on the lower's carry.
  always @(posedge clk or posedge rst) begin : model
    int nx;
    int lv;
    bit e;
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        cnt_m[i] <= rst_m[i];
        car_m[i] <= 1'b0;
        cd_m[i]  <= 1'b1;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        e  = (i == 5) ? car_m[4] : en_s[i];
        nx = (cnt_m[i] + 1) % mod_m[i];
        if (load_s[i]) begin
          lv = int'(ival_s[i]) % (1 << wid_m[i]);
          cnt_m[i] <= (lv < mod_m[i]) ? lv : 0;
          car_m[i] <= 1'b0;
        end else if (adj_s[i]) begin
          cnt_m[i] <= nx;
          car_m[i] <= 1'b0;
        end else if (e) begin
          cnt_m[i] <= nx;
          car_m[i] <= (nx == 0);
          if (nx == 0 || nx == mod_m[i] / 2) cd_m[i] <= ~cd_m[i];
        end else begin
          car_m[i] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("model_count[%0d]", i), dcnt(i), cnt_m[i]);
        chk($sformatf("model_carry[%0d]", i), dcar(i), int'(car_m[i]));
        chk($sformatf("model_clkdiv[%0d]", i), dcd(i), int'(cd_m[i]));
      end
    end
  end

  task automatic idle_all();
    for (int i = 0; i < NI; i++) begin
      en_s[i] = 1'b0; load_s[i] = 1'b0; adj_s[i] = 1'b0; ival_s[i] = 4'd0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_cnt [12] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0};
  int exp_cd  [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
  int exp10   [3]  = '{8, 9, 0};
  int hi_wraps;
  int lo_wrap_prev;
  int prev_hi;
  int prev_lo;
  int late;

  initial begin
    rst = 1'b0;
    idle_all();
    #2 rst = 1'b1;
    #1;
    chk("reset_count6", int'(c0), 0);
    chk("reset_carry6", int'(k0), 0);
    chk("reset_clkdiv6", int'(d0), 1);
    chk("reset_count10_ival", int'(c1), 7);
    chk_en = 1'b1;
    #9 rst = 1'b0;
    step();

    // Twelve consecutive ticks on the MODULO=6 digit.
    en_s[0] = 1'b1;
    for (int t = 0; t < 12; t++) begin
      step();
      chk($sformatf("tick6_count_%0d", t + 1), int'(c0), exp_cnt[t]);
      chk($sformatf("tick6_carry_%0d", t + 1), int'(k0), (t == 5 || t == 11) ? 1 : 0);
      chk($sformatf("tick6_clkdiv_%0d", t + 1), int'(d0), exp_cd[t]);
    end
    en_s[0] = 1'b0;

    // Load beats a coincident tick; out-of-range load value clears.
    load_s[0] = 1'b1; ival_s[0] = 4'd4; en_s[0] = 1'b1;
    step();
    chk("load4_count", int'(c0), 4);
    chk("load4_carry", int'(k0), 0);
    chk("load4_clkdiv", int'(d0), 1);
    ival_s[0] = 4'd9; en_s[0] = 1'b0;
    step();
    chk("load9_count", int'(c0), 0);
    ival_s[0] = 4'd5;
    step();
    load_s[0] = 1'b0;

    // Set-mode adjust from 5 with en toggling underneath.
    adj_s[0] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      en_s[0] = (t % 2 == 0);
      step();
      chk($sformatf("adj_count_%0d", t), int'(c0), t);
      chk($sformatf("adj_carry_%0d", t), int'(k0), 0);
      chk($sformatf("adj_clkdiv_%0d", t), int'(d0), 1);
    end
    adj_s[0] = 1'b0; en_s[0] = 1'b0;

    // MODULO=10 digit from IVAL=7.
    en_s[1] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step();
      chk($sformatf("m10_count_%0d", t), int'(c1), exp10[t]);
      chk($sformatf("m10_carry_%0d", t), int'(k1), (t == 2) ? 1 : 0);
      chk($sformatf("m10_clkdiv_%0d", t), int'(d1), (t == 2) ? 0 : 1);
    end
    en_s[1] = 1'b0;

    // Bring the MODULO=6 digit to 4 then reset between clock edges.
    en_s[0] = 1'b1;
    step();
    step();
    en_s[0] = 1'b0;
    chk("pre_reset_count6", int'(c0), 4);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_count6", int'(c0), 0);
    chk("async_reset_carry6", int'(k0), 0);
    chk("async_reset_clkdiv6", int'(d0), 1);
    chk("async_reset_count10", int'(c1), 7);
    @(negedge clk);
    #2 rst = 1'b0;
    step();

    // 60 ticks through the two-digit chain, plus one cycle for the upper digit to follow.
    hi_wraps = 0; late = 0; lo_wrap_prev = 0;
    prev_hi = int'(c5); prev_lo = int'(c4);
    en_s[4] = 1'b1;
    for (int t = 0; t < 61; t++) begin
      if (t == 60) en_s[4] = 1'b0;
      step();
      if (prev_hi == 5 && int'(c5) == 0) begin
        hi_wraps++;
        if (!lo_wrap_prev) late++;
      end
      lo_wrap_prev = (prev_lo == 9 && int'(c4) == 0);
      prev_hi = int'(c5); prev_lo = int'(c4);
    end
    chk("chain_hi_wraps", hi_wraps, 1);
    chk("chain_hi_wrap_not_after_lo_wrap", late, 0);
    chk("chain_lo_final", int'(c4), 0);
    chk("chain_hi_final", int'(c5), 0);

    // Randomised mix on the independent digits; the model checks every cycle.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 5; i++) begin
        load_s[i] = ($urandom_range(0, 15) == 0);
        adj_s[i]  = ($urandom_range(0, 9) == 0);
        en_s[i]   = (t % 200 < 50) ? 1'b1 : ($urandom_range(0, 1) == 1);
        ival_s[i] = 4'($urandom_range(0, 15));
      end
      step();
    end
    idle_all();
    step();
    step();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_modn.md
Name: count_modn

Overview:
- Parametrised modulo-N digit counter for the watch time chain: seconds, minutes, 10-minute and hour digits.
- Successor to the fixed 0-5 ripple-clocked digit; runs fully synchronous on one clock, with a tick enable instead of a derived clock.
- Adds carry-out pulse, registered divided-clock output, runtime load and a set-mode adjust path.
- Instances chain via carry_o -> en_i of the next digit; count_o feeds the 7-segment encoder.

Parameters:
- MODULO, 6: count range 0..MODULO-1; legal range 2..2**WIDTH.
- WIDTH, 4: width of count_o and ival_i.
- IVAL, 0: count value on reset; must be < MODULO.

Ports:
- clk_i  input  1  system clock; all state on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- en_i  input  1  count tick, one clk_i cycle wide (carry of previous digit or prescaler).
- load_i  input  1  synchronous load of ival_i.
- ival_i  input  WIDTH  runtime load value.
- adj_i  input  1  set-mode increment: wraps, no carry, no clkdiv toggle.
- count_o  output  WIDTH  current digit value, binary encoded.
- carry_o  output  1  one-cycle pulse on wrap MODULO-1 -> 0 under en_i.
- clkdiv_o  output  1  registered divided clock, period MODULO ticks.

Behaviour:
- Reset (rst_i=1, asynchronous, overrides everything): count_o=IVAL, carry_o=0, clkdiv_o=1. Release is synchronous to clk_i; first update is on the edge after release.
- Priority per clk_i edge: load_i > adj_i > en_i > hold.
- Load: count_o <= ival_i if ival_i < MODULO, else 0. carry_o <= 0, clkdiv_o holds. Tick is dropped if coincident.
- Adjust (adj_i=1, load_i=0):
  - count_o <= (count_o==MODULO-1) ? 0 : count_o+1.
  - carry_o <= 0, clkdiv_o holds, en_i ignored that cycle.
  - Level sensitive: held N cycles gives N increments.
- Tick (en_i=1, no load/adj):
  - count_o <= (count_o==MODULO-1) ? 0 : count_o+1.
  - carry_o <= (count_o==MODULO-1).
- clkdiv_o toggles on a tick cycle when count_o==HALF-1 or count_o==MODULO-1, with HALF=MODULO/2 (floor).
  - MODULO=6: toggles at 2 and 5, so 50% duty at 1/6 tick rate.
  - Odd MODULO: duty is HALF:(MODULO-HALF).
  - MODULO=2: toggles every tick.
- No tick: count_o, clkdiv_o hold; carry_o <= 0.
- Latency:
  - carry_o is registered. It is high in the same cycle count_o first reads 0 after a wrap, and low the next cycle.
  - Chained digits therefore update one clk_i later per stage. This is acceptable.
- carry_o is never high two consecutive cycles unless en_i wraps on consecutive cycles (MODULO reached every cycle).
- count_o never leaves 0..MODULO-1; arithmetic is WIDTH bits, unsigned, no overflow.
- Reset mid-operation aborts any load/adj/tick; outputs take reset values immediately (combinational through async reset).
- Elaboration check: fail if MODULO<2, MODULO>2**WIDTH, or IVAL>=MODULO.

Test Plan:
- Reset, MODULO=6, IVAL=0: rst_i=1 mid-count at 4 -> count_o=0, carry_o=0, clkdiv_o=1 without waiting for a clk_i edge.
- 12 ticks, MODULO=6:
  - count_o sequence 1,2,3,4,5,0,1,2,3,4,5,0.
  - carry_o high exactly after ticks 6 and 12.
  - clkdiv_o goes 0 after tick 3, 1 after tick 6, 0 after tick 9, 1 after tick 12.
- Load: ival_i=4, load_i=1 with en_i=1 -> count_o=4, carry_o=0, clkdiv_o unchanged. ival_i=9, load_i=1 -> count_o=0.
- Adjust: count_o=5, adj_i=1 for 3 cycles with en_i toggling -> count_o=0,1,2; carry_o stays 0; clkdiv_o constant.
- MODULO=10, WIDTH=4, IVAL=7 after reset: 3 ticks -> 8,9,0 with carry_o pulse on the third; clkdiv_o toggles on ticks where count was 4 and 9.
- Chain two instances (MODULO=10 -> MODULO=6) via carry_o->en_i: 60 ticks -> upper digit wraps 5->0 exactly once, one cycle after the lower digit wraps.
